// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 encodings,
// FSM state type and small address/size helpers.
package mem_pkg;

  localparam int unsigned XLEN         = 64;
  localparam int unsigned BYTE_SIZE    = 8;
  localparam int unsigned MEM_STEPS    = XLEN / BYTE_SIZE;
  localparam int unsigned OFFSET_W     = $clog2(MEM_STEPS);
  localparam int unsigned LANE_SHIFT_W = OFFSET_W + $clog2(BYTE_SIZE);

  // RISC-V load/store width encodings; 3'b111 is reserved.
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_D  = 3'b011,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101,
    LSU_WU = 3'b110
  } lsu_funct3_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } lsu_state_t;

  // Memory word index for a byte address; memory words are numbered from 1.
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr);
    return (addr >> OFFSET_W) + XLEN'(1);
  endfunction

  // One bit per byte lane covered by an access of the given size code.
  function automatic logic [MEM_STEPS-1:0] size_mask(input logic [1:0] size_code);
    case (size_code)
      2'b00:   return MEM_STEPS'(8'h01);
      2'b01:   return MEM_STEPS'(8'h03);
      2'b10:   return MEM_STEPS'(8'h0F);
      default: return '1;
    endcase
  endfunction

  // Misaligned offset, reserved funct3, or a zero-extending store.
  function automatic logic access_error(input logic                is_store,
                                        input logic [2:0]          funct3,
                                        input logic [OFFSET_W-1:0] offset);
    logic [OFFSET_W-1:0] align_mask;
    case (funct3[1:0])
      2'b00:   align_mask = OFFSET_W'(0);
      2'b01:   align_mask = OFFSET_W'(1);
      2'b10:   align_mask = OFFSET_W'(3);
      default: align_mask = OFFSET_W'(7);
    endcase
    return (funct3 == 3'b111) || (is_store && funct3[2]) ||
           ((offset & align_mask) != '0);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the data-memory read/write port.
// slave: the load/store unit. master: the requester and memory side.
interface load_store_unit_if;
  import mem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  logic            mem_read_enable;
  logic            mem_write_enable;
  logic [XLEN-1:0] mem_read_addr;
  logic [XLEN-1:0] mem_write_addr;
  logic [XLEN-1:0] mem_write_data;
  logic [XLEN-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read_enable, mem_write_enable, mem_read_addr,
    output mem_write_addr, mem_write_data
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_read_enable, mem_write_enable, mem_read_addr,
    input  mem_write_addr, mem_write_data
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word,
// and merges sub-doubleword store data into a read word.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]     word_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic [XLEN-1:0]     load_data_o,
  output logic [XLEN-1:0]     merge_word_o
);

  logic [LANE_SHIFT_W-1:0] shamt;
  logic [XLEN-1:0]         shifted;
  logic [XLEN-1:0]         wdata_shifted;
  logic [MEM_STEPS-1:0]    lane_mask;
  logic                    sign_ext;

  assign shamt         = {offset_i, {($clog2(BYTE_SIZE)){1'b0}}};
  assign shifted       = word_i >> shamt;
  assign wdata_shifted = wdata_i << shamt;
  assign lane_mask     = size_mask(funct3_i[1:0]) << offset_i;
  assign sign_ext      = ~funct3_i[2];

  // Truncate the shifted word to the access size, then sign/zero extend.
  always_comb begin
    load_data_o = shifted;
    case (funct3_i[1:0])
      2'b00:   load_data_o = {{(XLEN-8){sign_ext & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data_o = {{(XLEN-16){sign_ext & shifted[15]}}, shifted[15:0]};
      2'b10:   load_data_o = {{(XLEN-32){sign_ext & shifted[31]}}, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

  // Replace only the addressed lanes; every other lane keeps the read value.
  always_comb begin
    merge_word_o = word_i;
    for (int i = 0; i < MEM_STEPS; i++) begin
      if (lane_mask[i]) begin
        merge_word_o[i*BYTE_SIZE +: BYTE_SIZE] = wdata_shifted[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives the doubleword
// memory port (with read-modify-write for narrow stores) and returns one
// response per request.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_t          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                is_store_q, is_store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [XLEN-1:0]     word_idx_q, word_idx_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                error_q, error_d;

  logic [XLEN-1:0]     load_data;
  logic [XLEN-1:0]     merge_word;
  logic                req_err;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  lsu_lane_align u_align (
    .word_i       (bus.mem_read_data),
    .offset_i     (offset_q),
    .funct3_i     (funct3_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_word_o (merge_word)
  );

  assign req_err = access_error(bus.req_is_store, bus.req_funct3,
                                bus.req_addr[OFFSET_W-1:0]);

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, request fields included, is cleared on reset so
    // no stale request (e.g. a half-done read-modify-write) survives it.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      word_idx_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: request capture, read wait, merge and response hold.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    word_idx_d = word_idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          offset_d   = bus.req_addr[OFFSET_W-1:0];
          word_idx_d = word_index(bus.req_addr);
          wdata_d    = bus.req_wdata;
          rdata_d    = '0;
          cnt_d      = '0;
          error_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (bus.req_is_store && (bus.req_funct3 == LSU_D)) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          if (is_store_q) begin
            wdata_d = merge_word;
            state_d = WR_ISSUE;
          end else begin
            rdata_d = load_data;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR_ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state so strobes last exactly one state.
  assign bus.req_ready        = (state_q == IDLE);
  assign bus.mem_read_enable  = (state_q == RD_ISSUE);
  assign bus.mem_write_enable = (state_q == WR_ISSUE);
  assign bus.mem_read_addr    = bus.mem_read_enable  ? word_idx_q : '0;
  assign bus.mem_write_addr   = bus.mem_write_enable ? word_idx_q : '0;
  assign bus.mem_write_data   = bus.mem_write_enable ? wdata_q    : '0;
  assign bus.resp_valid       = (state_q == RESP);
  assign bus.resp_rdata       = bus.resp_valid ? rdata_q : '0;
  assign bus.resp_error       = bus.resp_valid & error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single requests with
// hand-computed results, plus response back-pressure and mid-RMW reset.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.READ_LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: 16 words, read data valid one cycle after the strobe.
  logic [63:0] mem [0:15];
  int rd_count = 0;
  int wr_count = 0;
  int overlap_count = 0;
  logic [63:0] last_raddr = '0;
  logic [63:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_read_data <= '0;
    end else if (bus.mem_read_enable) begin
      bus.mem_read_data <= (bus.mem_read_addr < 64'd16) ? mem[bus.mem_read_addr[3:0]] : '0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_read_enable) begin
        rd_count   <= rd_count + 1;
        last_raddr <= bus.mem_read_addr;
      end
      if (bus.mem_write_enable) begin
        wr_count   <= wr_count + 1;
        last_waddr <= bus.mem_write_addr;
        last_wdata <= bus.mem_write_data;
        if (bus.mem_write_addr < 64'd16) mem[bus.mem_write_addr[3:0]] <= bus.mem_write_data;
      end
      if (bus.mem_read_enable && bus.mem_write_enable) overlap_count <= overlap_count + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
    logic [63:0] exp_raddr;
    logic [63:0] exp_waddr;
    logic [63:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input logic is_store, input logic [2:0] funct3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_reads, input int exp_writes,
                              input logic [63:0] exp_raddr, input logic [63:0] exp_waddr,
                              input logic [63:0] exp_wdata);
    vec_t v;
    v.is_store = is_store;   v.funct3 = funct3;       v.addr = addr;
    v.wdata = wdata;         v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat;     v.exp_reads = exp_reads; v.exp_writes = exp_writes;
    v.exp_raddr = exp_raddr; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Issue one request at a negedge and wait (bounded) for its response.
  task automatic send_req(input logic is_store, input logic [2:0] funct3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = is_store;
    bus.req_funct3   = funct3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, rd0, wr0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    rd0 = rd_count;
    wr0 = wr_count;
    send_req(v.is_store, v.funct3, v.addr, v.wdata, lat);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_rdata"},   bus.resp_rdata, v.exp_rdata);
    check({tag, "_error"},   64'(bus.resp_error), 64'(v.exp_err));
    check({tag, "_reads"},   64'(rd_count - rd0), 64'(v.exp_reads));
    check({tag, "_writes"},  64'(wr_count - wr0), 64'(v.exp_writes));
    if (v.exp_reads > 0)  check({tag, "_raddr"}, last_raddr, v.exp_raddr);
    if (v.exp_writes > 0) begin
      check({tag, "_waddr"}, last_waddr, v.exp_waddr);
      check({tag, "_wdata"}, last_wdata, v.exp_wdata);
    end
    finish_resp();
    check({tag, "_idle_after"}, 64'({bus.req_ready, bus.resp_valid}), 64'b10);
  endtask

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    int lat, wr0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[4] = 64'h0123_4567_89AB_CDEF;
    mem[5] = 64'h8000_0000_F0E0_D0C0;

    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

    //            st   f3      addr       wdata                    rdata                    err lat rd wr raddr waddr  wdata
    vecs[0]  = mk(1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0,                  0, 2, 0, 1, 0, 3, 64'h1122334455667788);
    vecs[1]  = mk(0, 3'b000, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF88,                  0, 3, 1, 0, 3, 0, 0);
    vecs[2]  = mk(0, 3'b100, 64'h10, 64'h0, 64'h0000000000000088,                  0, 3, 1, 0, 3, 0, 0);
    vecs[3]  = mk(0, 3'b000, 64'h17, 64'h0, 64'h0000000000000011,                  0, 3, 1, 0, 3, 0, 0);
    vecs[4]  = mk(0, 3'b001, 64'h12, 64'h0, 64'h0000000000005566,                  0, 3, 1, 0, 3, 0, 0);
    vecs[5]  = mk(0, 3'b110, 64'h10, 64'h0, 64'h0000000055667788,                  0, 3, 1, 0, 3, 0, 0);
    vecs[6]  = mk(0, 3'b010, 64'h20, 64'h0, 64'hFFFFFFFFF0E0D0C0,                  0, 3, 1, 0, 5, 0, 0);
    vecs[7]  = mk(0, 3'b110, 64'h20, 64'h0, 64'h00000000F0E0D0C0,                  0, 3, 1, 0, 5, 0, 0);
    vecs[8]  = mk(0, 3'b101, 64'h26, 64'h0, 64'h0000000000008000,                  0, 3, 1, 0, 5, 0, 0);
    vecs[9]  = mk(0, 3'b001, 64'h26, 64'h0, 64'hFFFFFFFFFFFF8000,                  0, 3, 1, 0, 5, 0, 0);
    vecs[10] = mk(0, 3'b011, 64'h18, 64'h0, 64'h0123456789ABCDEF,                  0, 3, 1, 0, 4, 0, 0);
    vecs[11] = mk(1, 3'b001, 64'h12, 64'hABCD, 64'h0,                              0, 4, 1, 1, 3, 3, 64'h11223344ABCD7788);
    vecs[12] = mk(0, 3'b011, 64'h10, 64'h0, 64'h11223344ABCD7788,                  0, 3, 1, 0, 3, 0, 0);
    vecs[13] = mk(1, 3'b000, 64'h17, 64'hFFFFFFFFFFFFFF5A, 64'h0,                  0, 4, 1, 1, 3, 3, 64'h5A223344ABCD7788);
    vecs[14] = mk(1, 3'b010, 64'h14, 64'h0000000099AABBCC, 64'h0,                  0, 4, 1, 1, 3, 3, 64'h99AABBCCABCD7788);
    vecs[15] = mk(0, 3'b011, 64'h10, 64'h0, 64'h99AABBCCABCD7788,                  0, 3, 1, 0, 3, 0, 0);
    vecs[16] = mk(0, 3'b010, 64'h13, 64'h0, 64'h0,                                 1, 1, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 3'b110, 64'h10, 64'h1234, 64'h0,                              1, 1, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 3'b111, 64'h10, 64'h0, 64'h0,                                 1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 3'b011, 64'h14, 64'h5555, 64'h0,                              1, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 3'b001, 64'h11, 64'h0, 64'h0,                                 1, 1, 0, 0, 0, 0, 0);
    vecs[21] = mk(1, 3'b100, 64'h10, 64'h77, 64'h0,                                1, 1, 0, 0, 0, 0, 0);
    vecs[22] = mk(0, 3'b100, 64'h27, 64'h0, 64'h0000000000000080,                  0, 3, 1, 0, 5, 0, 0);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready",  64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_strobes",    64'({bus.mem_read_enable, bus.mem_write_enable}), 64'd0);
    check("rst_rdata",      bus.resp_rdata, 64'd0);
    check("rst_wdata",      bus.mem_write_data, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Back-pressure: response held stable while resp_ready stays low.
    send_req(1'b0, 3'b000, 64'h10, 64'h0, lat);
    check("hold_latency", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), 64'(bus.resp_valid), 64'd1);
      check($sformatf("hold%0d_rdata", i), bus.resp_rdata, 64'hFFFFFFFFFFFFFF88);
      check($sformatf("hold%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    finish_resp();
    check("hold_idle_after", 64'({bus.req_ready, bus.resp_valid}), 64'b10);

    // Reset during the read wait of a byte store: no write may follow.
    wr0 = wr_count;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 64'h10; bus.req_wdata = 64'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_rst_rd_issue", 64'(bus.mem_read_enable), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmw_rst_req_ready",  64'(bus.req_ready), 64'd1);
    check("rmw_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rmw_rst_strobes",    64'({bus.mem_read_enable, bus.mem_write_enable}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rmw_rst_no_write", 64'(wr_count - wr0), 64'd0);
    check("rmw_rst_idle",     64'({bus.req_ready, bus.resp_valid}), 64'b10);

    run_vec(mk(0, 3'b100, 64'h10, 64'h0, 64'h88, 0, 3, 1, 0, 3, 0, 0), 100);
    run_vec(mk(1, 3'b000, 64'h10, 64'h77, 64'h0, 0, 4, 1, 1, 3, 3, 64'h99AABBCCABCD7777), 101);

    check("no_strobe_overlap", 64'(overlap_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the data memory port: takes one load/store request at a time from the execute/memory stage and drives the doubleword-wide memory read/write interface.
- Handles byte-lane selection, sign/zero extension for loads, and read-modify-write for sub-doubleword stores.
- Flags misaligned or illegal accesses without touching memory.
- Returns one response per accepted request through a valid/ready handshake.

Parameters:
- XLEN, 64, data/address width; byte address space.
- BYTE_SIZE, 8, bits per byte lane.
- MEM_STEPS, XLEN/BYTE_SIZE, byte lanes per memory word (8).
- READ_LATENCY, 1, cycles from mem_read_enable until mem_read_data is valid (1..3).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal access.
- mem_read_enable  out  1  memory read strobe.
- mem_write_enable  out  1  memory write strobe.
- mem_read_addr  out  XLEN  memory word index.
- mem_write_addr  out  XLEN  memory word index.
- mem_write_data  out  XLEN  full word to write.
- mem_read_data  in  XLEN  full word read.

Behaviour:
- Reset (async): state IDLE. Outputs: req_ready=1, all other outputs 0, internal request registers cleared.
- Memory word index = (req_addr >> 3) + 1. Lane offset = req_addr[2:0].
- Accept: handshake when req_valid && req_ready. The request is registered; inputs are ignored afterwards.
- Decode:
  - Size 1/2/4/8 bytes from funct3[1:0]; funct3[2] = zero-extend.
  - Misaligned if offset is not a multiple of size.
  - Illegal: funct3=111; store with funct3[2]=1.
- Error path: IDLE -> RESP. resp_error=1, no memory strobe is ever asserted.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- Load: IDLE -> RD_ISSUE (mem_read_enable=1 for exactly one cycle) -> RD_WAIT (counter of READ_LATENCY cycles; mem_read_data captured in the last cycle) -> RESP.
  - Lane extract: (word >> 8*offset) truncated to size, then sign- or zero-extended to XLEN.
- SD store: IDLE -> WR_ISSUE (mem_write_enable=1 for one cycle, mem_write_data=req_wdata) -> RESP.
- Sub-doubleword store (read-modify-write): IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> RESP.
  - Merge replaces only the size bytes at offset with the low bytes of req_wdata; all other lanes keep the read value.
- Latency, accept cycle to resp_valid (READ_LATENCY=1):
  - Load: 3 cycles.
  - SD: 2 cycles.
  - Sub-word store: 4 cycles.
  - Error: 1 cycle.
- RESP: resp_valid, resp_rdata and resp_error held stable until resp_ready. Return to IDLE on the same edge. No new acceptance in the same cycle as the response handshake.
- Strobes: mem_read_enable and mem_write_enable are never high together. Addresses and write data are held constant while the corresponding strobe is high; strobes are 0 in every other state.
- Reset mid-operation: return to IDLE immediately. A pending RMW write is dropped; no partial write is issued after reset.
- Address wrap: the index is computed modulo 2^XLEN; no special handling.

Decomposition:
- Shared package (mem_pkg): funct3 encodings (LSU_B/H/W/D/BU/HU/WU), lsu_state_t enum, MEM_STEPS constant, word-index function.
- One sub-module, lsu_lane_align: combinational lane extract/extend and store-merge, shared by the load and RMW paths.

Test Plan:
- SD at 0x10, data 0x1122334455667788 -> one write strobe, mem_write_addr=3, mem_write_data=0x1122334455667788, resp_valid 2 cycles after accept, resp_error=0.
- LB/LBU at 0x10 with memory word 3 = 0x1122334455667788 -> LB rdata 0xFFFFFFFFFFFFFF88; LBU rdata 0x0000000000000088; LB at 0x17 rdata 0x0000000000000011.
- SH at 0x12, wdata 0xABCD, word 3 as above -> read addr 3, then write 0x11223344ABCD7788; read and write strobes never overlap.
- LW at 0x13 and store with funct3=110 -> resp_error=1, resp_rdata=0, zero memory strobes, response 1 cycle after accept.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable throughout, req_ready=0; IDLE after the handshake.
- Assert rst during RD_WAIT of an SB -> outputs return to reset values immediately, no write strobe ever issued, next request processed normally.
